// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared seven-segment encodings and blanking constants.
// Revision : 1.0
// ============================================================================
package seven_seg_pkg;

   localparam logic [6:0] c_seg_off = 7'h7F;
   localparam logic [3:0] c_an_off  = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns indexed by hex value.
   localparam logic [6:0] c_seg_table [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_pattern(input logic [3:0] hex);
      return c_seg_table[hex];
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Purpose  : Combinational hex nibble to active-low seven-segment decoder.
// Revision : 1.0
// ============================================================================
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = hex_pattern(i_hex);

endmodule
`default_nettype wire

// File: rtl/seven_seg_dis.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_dis
// Purpose  : Four-digit multiplexed hex display driver with registered pins.
// Revision : 1.0
// ============================================================================
module seven_seg_dis
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int CNT_W = REFRESH_BITS + 2;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             dp_q, dp_d;

   logic [1:0]       w_sel;
   logic [3:0]       w_nibble;
   logic [6:0]       w_seg_next;
   logic [3:0]       w_an_next;

   // Top two counter bits pick the digit; data_in is sampled live, not latched.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      w_sel     = cnt_q[CNT_W-1 -: 2];
      w_nibble  = data_in[{w_sel, 2'b00} +: 4];
      w_an_next = ~(4'b0001 << w_sel);
      seg_d     = w_seg_next;
      an_d      = w_an_next;
      dp_d      = 1'b1;
   end

   hex_to_seg u_hex_to_seg (
      .i_hex (w_nibble),
      .o_seg (w_seg_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         seg_q <= c_seg_off;
         an_q  <= c_an_off;
         dp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         seg_q <= seg_d;
         an_q  <= an_d;
         dp_q  <= dp_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_dis.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_dis
// Purpose  : Scoreboard bench for seven_seg_dis against a cycle-index model.
// Revision : 1.0
// ============================================================================
module tb_seven_seg_dis;

   localparam int TB_RB  = 6;
   localparam int PERIOD = 1 << TB_RB;
   localparam int SCAN   = 4 * PERIOD;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic [3:0] nib;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = 16'h0000;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   int   n = 0;
   bit   mon_en = 1'b1;
   bit   seen [16];

   seven_seg_dis #(.REFRESH_BITS(TB_RB)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .seg     (seg),
      .dp      (dp),
      .an      (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return 7;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the k-th edge after reset release shows digit (k / PERIOD) % 4.
   task automatic push_expected(input logic [15:0] d);
      exp_t e;
      int   digit;
      data_in = d;
      digit   = (n / PERIOD) % 4;
      e.nib   = 4'((d >> (4 * digit)) & 16'hF);
      e.an    = ~(4'b0001 << digit);
      e.seg   = pat(e.nib);
      sb_q.push_back(e);
      n = (n + 1) % SCAN;
   endtask

   task automatic drive_cycle(input logic [15:0] d);
      @(negedge clk);
      push_expected(d);
   endtask

   task automatic release_reset(input logic [15:0] d);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      push_expected(d);
   endtask

   task automatic async_reset(input int hold);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_an",  32'(an),  32'hF);
      check("async_seg", 32'(seg), 32'h7F);
      check("async_dp",  32'(dp),  32'h1);
      repeat (hold) @(negedge clk);
   endtask

   // Monitor: pops one expectation per out-of-reset edge and checks invariants.
   exp_t       m_e;
   logic [3:0] prev_an = 4'hF;
   int         run_len = 0;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (rst) begin
            check("rst_an",  32'(an),  32'hF);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dp",  32'(dp),  32'h1);
            prev_an = 4'hF;
            run_len = 0;
         end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL underrun: DUT output with no expectation at %0t", $time);
         end else begin
            m_e = sb_q.pop_front();
            check("an",     32'(an),  32'(m_e.an));
            check("seg",    32'(seg), 32'(m_e.seg));
            check("dp",     32'(dp),  32'h1);
            check("onehot", 32'($countones(~an)), 32'd1);
            if (an === m_e.an && seg === m_e.seg) seen[m_e.nib] = 1'b1;
            if (an === prev_an) begin
               run_len++;
            end else begin
               if (prev_an != 4'hF) begin
                  check("dwell", 32'(run_len), 32'(PERIOD));
                  check("scan_order", 32'(an_idx(an)), 32'((an_idx(prev_an) + 1) % 4));
               end
               prev_an = an;
               run_len = 1;
            end
         end
      end
   end

   initial begin
      repeat (25) @(negedge clk);

      release_reset(16'h0123);
      repeat (2 * SCAN) drive_cycle(16'h0123);
      foreach (seen[i]) if (i < 4) check($sformatf("seen_%0h", i), 32'(seen[i]), 32'h1);

      repeat (2 * SCAN) drive_cycle(16'h4567);
      repeat (2 * SCAN) drive_cycle(16'h89AB);
      repeat (2 * SCAN) drive_cycle(16'hCDEF);
      foreach (seen[i]) check($sformatf("seen_all_%0h", i), 32'(seen[i]), 32'h1);

      // Live data change while digit 0 is lit.
      async_reset(3);
      release_reset(16'h0000);
      repeat (10) drive_cycle(16'h0000);
      repeat (10) drive_cycle(16'h000F);

      repeat (3 * SCAN) drive_cycle(16'($urandom()));

      // Mid-scan reset while digit 2 is lit, then restart from digit 0.
      while (!((n / PERIOD) % 4 == 2 && n % PERIOD == 10)) drive_cycle(16'($urandom()));
      async_reset(4);
      release_reset(16'hBEEF);
      repeat (SCAN + 20) drive_cycle(16'($urandom()));

      @(posedge clk);
      #3 mon_en = 1'b0;
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_dis.md
SEVEN_SEG_DIS -- requirements
Module: seven_seg_dis

Interface
REQ-001 Parameter: REFRESH_BITS, default 12; number of clock cycles each digit is lit = 2^REFRESH_BITS.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: data_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-005 Port: seg  output  7  cathodes, active-low; seg[0]=a, seg[1]=b, ... seg[6]=g.
REQ-006 Port: dp  output  1  decimal point cathode, active-low.
REQ-007 Port: an  output  4  digit anodes, active-low, one-hot-low; an[i] enables digit i.

Function
REQ-008 The block SHALL hold a free-running refresh counter of REFRESH_BITS+2 bits, incremented every clk cycle and wrapping to 0.
REQ-009 The top 2 counter bits SHALL form the digit select sel.
- Each digit is active for exactly 2^REFRESH_BITS consecutive cycles.
- Scan order is 0,1,2,3,0,...
REQ-010 For sel=i, the block SHALL compute an_next = ~(4'b0001 << i) and nibble = data_in[4i+3:4i].
REQ-011 The block SHALL decode nibble to seg_next using the active-low patterns below (hex value of seg[6:0]):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-012 seg, an and dp SHALL be registered outputs loaded from seg_next/an_next every cycle, giving one cycle latency from counter value and data_in to pins.
REQ-013 data_in SHALL NOT be latched; a change to data_in SHALL appear on seg within one cycle while the affected digit is active.
REQ-014 dp SHALL be driven 1 (off) at all times.
REQ-015 Exactly one an bit SHALL be 0 in every cycle after the first post-reset clock edge; never zero or two-or-more.
REQ-016 Counter wrap from all-ones to 0 SHALL move sel from 3 to 0 with no extra or skipped cycle.
REQ-017 With REFRESH_BITS=12, a full 4-digit scan SHALL take 16384 cycles.

Reset
REQ-018 While rst=1, the refresh counter SHALL be 0, an=4'b1111 (all digits off), seg=7'h7F (all segments off) and dp=1, regardless of clk.
REQ-019 On the first rising edge after rst deasserts, an SHALL become 4'b1110 and seg SHALL show data_in[3:0].
REQ-020 Reset asserted mid-scan SHALL immediately blank all outputs and restart the scan at digit 0.

Structure
REQ-021 The 16-entry hex-to-segment pattern table and the all-off constants (7'h7F, 4'b1111) SHALL live in a shared package, seven_seg_pkg.
REQ-022 The decoder SHALL be one combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out).
- The counter, mux and output registers reside in seven_seg_dis.

Verification
REQ-023 Reset: hold rst=1 for 25 cycles -> an=1111, seg=7F, dp=1 throughout; first edge after release -> an=1110.
REQ-024 data_in=16'h0123, REFRESH_BITS=12, run 50000 cycles -> observed per-digit sequence an=1110/seg=30, 1101/24, 1011/79, 0111/40, each held 4096 cycles.
REQ-025 Sweep data_in=16'h4567, 16'h89AB, 16'hCDEF (50000 cycles each) -> all 16 patterns from REQ-011 appear on the correct anode.
REQ-026 Invariants every cycle after reset: dp=1 and an one-hot-low; digit 3->0 transition at counter wrap occurs after exactly 4096 cycles on digit 3.
REQ-027 Change data_in from 16'h0000 to 16'h000F while digit 0 is active -> seg goes from 40 to 0E one cycle later; an unchanged.
REQ-028 Assert rst while digit 2 is active -> outputs blank asynchronously; after release, scan restarts at an=1110.
